// File: rtl/alu_share_arbiter_if.sv
// alu_share_arbiter_if: request, ALU and response signals of the shared-ALU arbiter
interface alu_share_arbiter_if #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4
);
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_err;
  modport slave (
    input  req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    input  alu_result, alu_zero, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op,
    output alu_result, alu_zero, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_op,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
// Optional illegal-opcode reporting enabled by defining ALU_OPCODE_CHECK_EN.
module alu_share_arbiter #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4
) (
  input logic clk,
  input logic reset_n,
  alu_share_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'b00, EXEC = 2'b01, RESP = 2'b10} state_t;
  state_t            state_q, state_d;
  logic [1:0]        ready;
  logic              grant_q, grant_d, last_q, last_d, id_q, id_d;
  logic              vld_q, vld_d, zero_q, zero_d, err_q, err_d, pend_q, pend_d;
  logic              illegal;
  logic [OP_W-1:0]   sel_op;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
`ifdef ALU_OPCODE_CHECK_EN
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return !(op inside {OP_W'(0), OP_W'(1), OP_W'(2), OP_W'(6),
                        OP_W'(12), OP_W'(13), OP_W'(8), OP_W'(7)});
  endfunction
`endif
  always_comb begin
    ready = 2'b00;
    if (state_q == IDLE) ready = (&bus.req_valid) ? (last_q ? 2'b01 : 2'b10) : bus.req_valid;
    sel_op = ready[1] ? bus.req1_op : bus.req0_op;
`ifdef ALU_OPCODE_CHECK_EN
    illegal = op_illegal(sel_op);
`else
    illegal = 1'b0;
`endif
  end
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    id_d    = id_q;
    vld_d   = vld_q;
    zero_d  = zero_q;
    err_d   = err_q;
    pend_d  = pend_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    res_d   = res_q;
    case (state_q)
      IDLE: if (|ready) begin
        grant_d = ready[1];
        a_d     = ready[1] ? bus.req1_a : bus.req0_a;
        b_d     = ready[1] ? bus.req1_b : bus.req0_b;
        op_d    = sel_op;
        pend_d  = illegal;
        state_d = EXEC;
      end
      EXEC: begin
        res_d   = pend_q ? '0 : bus.alu_result;
        zero_d  = !pend_q && bus.alu_zero;
        err_d   = pend_q;
        id_d    = grant_q;
        vld_d   = 1'b1;
        state_d = RESP;
      end
      RESP: if (bus.rsp_ready) begin
        vld_d   = 1'b0;
        err_d   = 1'b0;
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      id_q    <= 1'b0;
      vld_q   <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      pend_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      id_q    <= id_d;
      vld_q   <= vld_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      pend_q  <= pend_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      res_q   <= res_d;
    end
  end
  assign bus.req_ready  = ready;
  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.rsp_valid  = vld_q;
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = res_q;
  assign bus.rsp_zero   = zero_q;
  assign bus.rsp_err    = err_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed vector table plus hold/reset sequences with a reference ALU
module tb_alu_share_arbiter;
  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_fail = 0;
  alu_share_arbiter_if #(.DATA_W(64), .OP_W(4)) bus ();
  alu_share_arbiter #(.DATA_W(64), .OP_W(4)) dut (.clk(clk), .reset_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  logic [63:0] r;
  always_comb begin
    case (bus.alu_op)
      4'h0:    r = bus.alu_a & bus.alu_b;
      4'h1:    r = bus.alu_a | bus.alu_b;
      4'h2:    r = bus.alu_a + bus.alu_b;
      4'h6:    r = bus.alu_a - bus.alu_b;
      4'h7:    r = {63'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
      4'hC:    r = ~(bus.alu_a | bus.alu_b);
      4'h8:    r = bus.alu_a << bus.alu_b[5:0];
      default: r = bus.alu_a ^ bus.alu_b;
    endcase
    bus.alu_result = r;
    bus.alu_zero   = (r == 64'd0);
  end
  typedef struct {
    logic [1:0]  v;
    logic [63:0] a0, b0;
    logic [3:0]  op0;
    logic [63:0] a1, b1;
    logic [3:0]  op1;
    logic [1:0]  rdy;
    logic [63:0] res;
    logic        z;
    logic        e;
  } vec_t;
  vec_t vt[9];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_op(input vec_t t, input string tag);
    bus.req_valid = t.v;
    bus.req0_a = t.a0; bus.req0_b = t.b0; bus.req0_op = t.op0;
    bus.req1_a = t.a1; bus.req1_b = t.b1; bus.req1_op = t.op1;
    #1 check({tag, "_ready"}, 64'(bus.req_ready), 64'(t.rdy));
    step();
    bus.req_valid = 2'b00;
    check({tag, "_busy"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_alu_a"}, bus.alu_a, t.rdy[1] ? t.a1 : t.a0);
    check({tag, "_alu_op"}, 64'(bus.alu_op), 64'(t.rdy[1] ? t.op1 : t.op0));
    check({tag, "_novld"}, 64'(bus.rsp_valid), 64'd0);
    step();
    check({tag, "_vld"}, 64'(bus.rsp_valid), 64'd1);
    check({tag, "_id"}, 64'(bus.rsp_id), 64'(t.rdy[1]));
    check({tag, "_res"}, bus.rsp_result, t.res);
    check({tag, "_zero"}, 64'(bus.rsp_zero), 64'(t.z));
    check({tag, "_err"}, 64'(bus.rsp_err), 64'(t.e));
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check({tag, "_done"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_errclr"}, 64'(bus.rsp_err), 64'd0);
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_ready"}, 64'(bus.req_ready), 64'd0);
    check({tag, "_vld"}, 64'(bus.rsp_valid), 64'd0);
    check({tag, "_id"}, 64'(bus.rsp_id), 64'd0);
    check({tag, "_res"}, bus.rsp_result, 64'd0);
    check({tag, "_zero"}, 64'(bus.rsp_zero), 64'd0);
    check({tag, "_err"}, 64'(bus.rsp_err), 64'd0);
    check({tag, "_alu_a"}, bus.alu_a, 64'd0);
    check({tag, "_alu_b"}, bus.alu_b, 64'd0);
    check({tag, "_alu_op"}, 64'(bus.alu_op), 64'd0);
  endtask
  initial begin
    vec_t t;
    vt[0] = '{2'b01, 64'd5, 64'd3, 4'h2, 64'd0, 64'd0, 4'h0, 2'b01, 64'd8, 1'b0, 1'b0};
    vt[1] = '{2'b10, 64'd0, 64'd0, 4'h0, 64'd100, 64'd1, 4'h6, 2'b10, 64'd99, 1'b0, 1'b0};
    vt[2] = '{2'b11, 64'hF0, 64'h0F, 4'h0, 64'hF0, 64'h0F, 4'h1, 2'b01, 64'd0, 1'b1, 1'b0};
    vt[3] = '{2'b11, 64'hF0, 64'h0F, 4'h0, 64'hF0, 64'h0F, 4'h1, 2'b10, 64'hFF, 1'b0, 1'b0};
    vt[4] = '{2'b11, '1, 64'd1, 4'h2, 64'd0, 64'd0, 4'hC, 2'b01, 64'd0, 1'b1, 1'b0};
    vt[5] = '{2'b11, '1, 64'd1, 4'h2, 64'd0, 64'd0, 4'hC, 2'b10, '1, 1'b0, 1'b0};
    vt[6] = '{2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 4'h7, 64'd0, 64'd0, 4'h0, 2'b01, 64'd1, 1'b0, 1'b0};
    vt[7] = '{2'b01, 64'd1, 64'd4, 4'h8, 64'd0, 64'd0, 4'h0, 2'b01, 64'd16, 1'b0, 1'b0};
`ifdef ALU_OPCODE_CHECK_EN
    vt[8] = '{2'b10, 64'd0, 64'd0, 4'h0, 64'd6, 64'd3, 4'hF, 2'b10, 64'd0, 1'b0, 1'b1};
`else
    vt[8] = '{2'b10, 64'd0, 64'd0, 4'h0, 64'd6, 64'd3, 4'hF, 2'b10, 64'd5, 1'b0, 1'b0};
`endif
    rst_n = 1'b0;
    bus.req_valid = 2'b00;
    bus.rsp_ready = 1'b0;
    bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    #12 check_zero("reset");
    @(negedge clk) rst_n = 1'b1;
    step();
    bus.req_valid = 2'b11;
    #1 check("first_contention", 64'(bus.req_ready), 64'd1);
    for (int i = 0; i < 9; i++) run_op(vt[i], $sformatf("v%0d", i));
    t = '{2'b10, 64'd1, 64'd1, 4'h2, 64'd7, 64'd7, 4'h6, 2'b10, 64'd0, 1'b1, 1'b0};
    bus.req_valid = t.v;
    bus.req0_a = t.a0; bus.req0_b = t.b0; bus.req0_op = t.op0;
    bus.req1_a = t.a1; bus.req1_b = t.b1; bus.req1_op = t.op1;
    #1 check("hold_ready", 64'(bus.req_ready), 64'd2);
    step();
    bus.req_valid = 2'b00;
    step();
    bus.req_valid = 2'b01;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("hold%0d_vld", i), 64'(bus.rsp_valid), 64'd1);
      check($sformatf("hold%0d_id", i), 64'(bus.rsp_id), 64'd1);
      check($sformatf("hold%0d_res", i), bus.rsp_result, 64'd0);
      check($sformatf("hold%0d_zero", i), 64'(bus.rsp_zero), 64'd1);
      check($sformatf("hold%0d_ready", i), 64'(bus.req_ready), 64'd0);
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    check("hold_release_vld", 64'(bus.rsp_valid), 64'd0);
    check("hold_release_ready", 64'(bus.req_ready), 64'd1);
    bus.req_valid = 2'b00;
    bus.req0_a = 64'd9; bus.req0_b = 64'd9; bus.req0_op = 4'h2;
    bus.req_valid = 2'b01;
    #1 check("rst_op_ready", 64'(bus.req_ready), 64'd1);
    step();
    bus.req_valid = 2'b00;
    check("rst_op_alu_a", bus.alu_a, 64'd9);
    rst_n = 1'b0;
    #1 check_zero("midreset");
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("discard%0d_vld", i), 64'(bus.rsp_valid), 64'd0);
    end
    bus.req_valid = 2'b11;
    #1 check("postrst_contention", 64'(bus.req_ready), 64'd1);
    t = '{2'b10, 64'd0, 64'd0, 4'h0, 64'd20, 64'd22, 4'h2, 2'b10, 64'd42, 1'b0, 1'b0};
    run_op(t, "postrst_req1");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
